// File: rtl/tp_cbus_pkg.sv
// Shared definitions for the cbus initiator: FSM state encoding and the
// cbus command encoding seen by the memory PHY/cbus arbiter.
package tp_cbus_pkg;

    // State encoding values
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RDATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        REQ   = ST_REQ,
        RDATA = ST_RDATA
    } state_t;

    // cbus command encoding
    localparam logic CBUS_CMD_WR = 1'b0;
    localparam logic CBUS_CMD_RD = 1'b1;

endpackage

// File: rtl/tp_cbus_initiator.sv
// Config-bus initiator: takes single-word host read/write commands, holds a
// request towards the PHY/cbus arbiter until the matching grant arrives and
// returns read data captured from the memory read port.
// Optional feature macro: TP_CBUS_INIT_TIMEOUT_EN enables the ungranted-request
// timeout (abort with host_err after TO_MAX cycles without a matching grant).
module tp_cbus_initiator
    import tp_cbus_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int TO_W   = 8,
    parameter int TO_MAX = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_host_req,
    input  logic          i_host_cmd,
    input  logic [AW-1:0] i_host_addr,
    input  logic [DW-1:0] i_host_wdata,
    output logic          o_host_ready,
    output logic          o_host_done,
    output logic          o_host_rvalid,
    output logic [DW-1:0] o_host_rdata,
    output logic          o_host_err,
    output logic          o_cbus_req,
    output logic          o_cbus_cmd,
    output logic [AW-1:0] o_cbus_addr,
    output logic [DW-1:0] o_cbus_wrdata,
    input  logic          i_cbus_waccept,
    input  logic          i_cbus_rresp,
    input  logic [DW-1:0] i_mem_rd_data
);

    state_t        r_state;
    logic          r_host_ready;
    logic          r_host_done;
    logic          r_host_rvalid;
    logic [DW-1:0] r_host_rdata;
    logic          r_cbus_req;
    logic          r_cmd;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    // A TO_MAX that does not fit the counter is a configuration error; the
    // marker block makes it visible in the elaborated hierarchy.
    if (TO_MAX >= (2 ** TO_W)) begin : g_to_max_exceeds_counter
    end

`ifdef TP_CBUS_INIT_TIMEOUT_EN
    localparam logic [TO_W-1:0] LP_TO_MAX = TO_W'(TO_MAX);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_host_err;
`endif

    // Request/grant FSM; every host and cbus output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_host_ready  <= 1'b1;
            r_host_done   <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= {DW{1'b0}};
            r_cbus_req    <= 1'b0;
            r_cmd         <= CBUS_CMD_WR;
            r_addr        <= {AW{1'b0}};
            r_wdata       <= {DW{1'b0}};
`ifdef TP_CBUS_INIT_TIMEOUT_EN
            r_to_cnt      <= {TO_W{1'b0}};
            r_host_err    <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses.
            r_host_done   <= 1'b0;
            r_host_rvalid <= 1'b0;
`ifdef TP_CBUS_INIT_TIMEOUT_EN
            r_host_err    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (i_host_req) begin
                        r_cmd        <= i_host_cmd;
                        r_addr       <= i_host_addr;
                        r_wdata      <= i_host_wdata;
                        r_host_ready <= 1'b0;
                        r_cbus_req   <= 1'b1;
                        r_state      <= REQ;
`ifdef TP_CBUS_INIT_TIMEOUT_EN
                        r_to_cnt     <= {TO_W{1'b0}};
`endif
                    end
                end
                REQ: begin
                    // Only a grant matching the latched command type counts;
                    // a grant on the same cycle as the limit still wins.
                    if ((r_cmd == CBUS_CMD_WR) && i_cbus_waccept) begin
                        r_cbus_req   <= 1'b0;
                        r_host_done  <= 1'b1;
                        r_host_ready <= 1'b1;
                        r_state      <= IDLE;
                    end else if ((r_cmd == CBUS_CMD_RD) && i_cbus_rresp) begin
                        r_cbus_req   <= 1'b0;
                        r_state      <= RDATA;
`ifdef TP_CBUS_INIT_TIMEOUT_EN
                    end else if (r_to_cnt == LP_TO_MAX) begin
                        r_cbus_req   <= 1'b0;
                        r_host_done  <= 1'b1;
                        r_host_err   <= 1'b1;
                        r_host_ready <= 1'b1;
                        r_state      <= IDLE;
                    end else begin
                        r_to_cnt     <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
`endif
                    end
                end
                RDATA: begin
                    // Memory read port presents data one cycle after the grant.
                    r_host_rdata  <= i_mem_rd_data;
                    r_host_rvalid <= 1'b1;
                    r_host_done   <= 1'b1;
                    r_host_ready  <= 1'b1;
                    r_state       <= IDLE;
                end
                default: begin
                    r_cbus_req   <= 1'b0;
                    r_host_ready <= 1'b1;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign o_host_ready  = r_host_ready;
    assign o_host_done   = r_host_done;
    assign o_host_rvalid = r_host_rvalid;
    assign o_host_rdata  = r_host_rdata;
    assign o_cbus_req    = r_cbus_req;
    assign o_cbus_cmd    = r_cmd;
    assign o_cbus_addr   = r_addr;
    assign o_cbus_wrdata = r_wdata;
`ifdef TP_CBUS_INIT_TIMEOUT_EN
    assign o_host_err    = r_host_err;
`else
    assign o_host_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tp_cbus_initiator.sv
// Self-checking bench for tp_cbus_initiator: directed vector table, randomized
// transactions against a latency/outcome model, and an asynchronous reset
// during an outstanding request.
module tb_tp_cbus_initiator;
    import tp_cbus_pkg::*;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int TO_W      = 8;
    localparam int TB_TO_MAX = 4;
`ifdef TP_CBUS_INIT_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_host_req = 1'b0;
    logic          i_host_cmd = 1'b0;
    logic [AW-1:0] i_host_addr = '0;
    logic [DW-1:0] i_host_wdata = '0;
    logic          o_host_ready, o_host_done, o_host_rvalid, o_host_err;
    logic [DW-1:0] o_host_rdata;
    logic          o_cbus_req, o_cbus_cmd;
    logic [AW-1:0] o_cbus_addr;
    logic [DW-1:0] o_cbus_wrdata;
    logic          i_cbus_waccept = 1'b0;
    logic          i_cbus_rresp = 1'b0;
    logic [DW-1:0] i_mem_rd_data = '0;

    int n_pass   = 0;
    int n_checks = 0;
    logic [DW-1:0] model_rdata = '0;

    tp_cbus_initiator #(.DW(DW), .AW(AW), .TO_W(TO_W), .TO_MAX(TB_TO_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_host_req(i_host_req), .i_host_cmd(i_host_cmd),
        .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata),
        .o_host_ready(o_host_ready), .o_host_done(o_host_done),
        .o_host_rvalid(o_host_rvalid), .o_host_rdata(o_host_rdata),
        .o_host_err(o_host_err),
        .o_cbus_req(o_cbus_req), .o_cbus_cmd(o_cbus_cmd),
        .o_cbus_addr(o_cbus_addr), .o_cbus_wrdata(o_cbus_wrdata),
        .i_cbus_waccept(i_cbus_waccept), .i_cbus_rresp(i_cbus_rresp),
        .i_mem_rd_data(i_mem_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;   // ungranted REQ cycles before the matching grant
        logic [31:0] rdata;
        bit          b2b;     // issue on the previous done cycle
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Outcome model: grant in cycle delay+1 (accept is cycle 0); a write
    // finishes one cycle after the grant, a read two. With the timeout, a
    // request still ungranted when the count reaches TO_MAX is aborted.
    function automatic bit m_abort(input int delay);
        return TO_ON && (delay > TB_TO_MAX);
    endfunction

    function automatic int m_latency(input logic cmd, input int delay);
        if (m_abort(delay)) return TB_TO_MAX + 2;
        return (cmd == CBUS_CMD_RD) ? delay + 3 : delay + 2;
    endfunction

    function automatic int m_req_cycles(input int delay);
        return m_abort(delay) ? TB_TO_MAX + 1 : delay + 1;
    endfunction

    // Issue one command in the current cycle and follow it to host_done.
    task automatic run_txn(input int id, input vec_t v);
        int c, req_cyc, gc, budget, exp_lat;
        bit seen, bad;
        exp_lat = m_latency(v.cmd, v.delay);
        budget  = exp_lat + 10;
        gc      = v.delay + 1;
        chk($sformatf("ready_at_issue#%0d", id), o_host_ready, 1'b1);
        i_host_req   = 1'b1;
        i_host_cmd   = v.cmd;
        i_host_addr  = v.addr;
        i_host_wdata = v.wdata;
        tick();
        i_host_req   = 1'b0;
        i_host_addr  = $urandom;
        i_host_wdata = $urandom;
        i_host_cmd   = 1'($urandom_range(0, 1));
        c = 1; req_cyc = 0; seen = 1'b0; bad = 1'b0;
        while (!seen && c < budget) begin
            if (o_host_done) begin
                seen = 1'b1;
            end else begin
                if (o_host_ready) bad = 1'b1;
                if (o_cbus_req) begin
                    req_cyc++;
                    if (o_cbus_addr !== v.addr || o_cbus_cmd !== v.cmd ||
                        o_cbus_wrdata !== v.wdata) bad = 1'b1;
                end
                if (v.cmd == CBUS_CMD_WR) begin
                    i_cbus_waccept = (c == gc);
                    i_cbus_rresp   = 1'($urandom_range(0, 1));
                end else begin
                    i_cbus_rresp   = (c == gc);
                    i_cbus_waccept = 1'($urandom_range(0, 1));
                end
                i_mem_rd_data = (c == gc + 1) ? v.rdata : $urandom;
                tick();
                c++;
            end
        end
        i_cbus_waccept = 1'b0;
        i_cbus_rresp   = 1'b0;
        chk($sformatf("done_seen#%0d", id), seen, 1'b1);
        chk($sformatf("latency#%0d", id), c, exp_lat);
        chk($sformatf("req_cycles#%0d", id), req_cyc, m_req_cycles(v.delay));
        chk($sformatf("req_stable_busy#%0d", id), bad, 1'b0);
        chk($sformatf("err#%0d", id), o_host_err, m_abort(v.delay));
        chk($sformatf("rvalid#%0d", id), o_host_rvalid,
            (v.cmd == CBUS_CMD_RD) && !m_abort(v.delay));
        if (v.cmd == CBUS_CMD_RD && !m_abort(v.delay)) model_rdata = v.rdata;
        chk($sformatf("rdata#%0d", id), o_host_rdata, model_rdata);
        chk($sformatf("ready_at_done#%0d", id), o_host_ready, 1'b1);
        chk($sformatf("req_low_at_done#%0d", id), o_cbus_req, 1'b0);
    endtask

    // Two quiet cycles; the done pulse must already be gone.
    task automatic idle_gap(input int id);
        tick();
        chk($sformatf("done_one_cycle#%0d", id), o_host_done, 1'b0);
        chk($sformatf("rvalid_one_cycle#%0d", id), o_host_rvalid, 1'b0);
        chk($sformatf("ready_idle#%0d", id), o_host_ready, 1'b1);
        tick();
    endtask

    vec_t vecs[8];

    initial begin
        vec_t rv;
        bit bad;
        vecs[0] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0,   32'h0,         1'b0};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0,         5,   32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0030, 32'hA5A5_5A5A, 1,   32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'h0000_0040, 32'h0,         0,   32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0050, 32'h1111_2222, 4,   32'h0,         1'b1};
        vecs[5] = '{1'b0, 32'h0000_0060, 32'h3333_4444, 9,   32'h0,         1'b0};
        vecs[6] = '{1'b1, 32'h0000_0070, 32'h0,         7,   32'h0BAD_F00D, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0080, 32'h5555_6666, 300, 32'h0,         1'b0};

        // Reset state
        #12;
        chk("rst_ready", o_host_ready, 1'b1);
        chk("rst_flags", {o_host_done, o_host_rvalid, o_host_err, o_cbus_req}, 4'b0000);
        chk("rst_rdata", o_host_rdata, 32'h0);
        chk("rst_cbus_addr", o_cbus_addr, 32'h0);
        #1 rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].b2b) idle_gap(i);
            run_txn(i, vecs[i]);
        end

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            rv.cmd   = 1'($urandom_range(0, 1));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.delay = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 9))
                                                   : int'($urandom_range(0, 3));
            rv.b2b   = 1'($urandom_range(0, 1));
            if (!rv.b2b) idle_gap(100 + i);
            run_txn(100 + i, rv);
        end

        // Reset while a read request is outstanding
        idle_gap(200);
        i_host_req  = 1'b1;
        i_host_cmd  = CBUS_CMD_RD;
        i_host_addr = 32'h0000_0055;
        tick();
        i_host_req = 1'b0;
        tick();
        tick();
        chk("midrst_req_before", o_cbus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_drop", o_cbus_req, 1'b0);
        chk("midrst_ready", o_host_ready, 1'b1);
        #2 rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_cbus_rresp  = 1'b1;
            i_mem_rd_data = $urandom;
            tick();
            if (o_host_done || o_host_rvalid || o_cbus_req || !o_host_ready) bad = 1'b1;
        end
        i_cbus_rresp = 1'b0;
        chk("midrst_quiet", bad, 1'b0);
        model_rdata = '0;
        chk("midrst_rdata", o_host_rdata, model_rdata);
        rv = '{1'b0, 32'h0000_0090, 32'h7777_8888, 2, 32'h0, 1'b0};
        run_txn(201, rv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tp_cbus_initiator.md
# tp_cbus_initiator

Config-bus initiator for two-port memory macros. It accepts single-word read/write commands from a host-side register/CPU port and drives the cbus request side of the memory's PHY/cbus arbiter. It holds each request until the arbiter grants it, and captures read data from the memory read port. It sits between the SoC control bus bridge and the arbiter that shares the memory with the PHY datapath.

## Interface
- DW, 32, data width
- AW, 32, address width
- TO_W, 8, timeout counter width
- TO_MAX, 255, cycles of ungranted request before abort (must be < 2^TO_W)

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- host_req  in  1  host command valid
- host_cmd  in  1  1 = read, 0 = write
- host_addr  in  AW  command address
- host_wdata  in  DW  write data
- host_ready  out  1  initiator idle, command accepted when host_req & host_ready
- host_done  out  1  one-cycle pulse, command finished (success or abort)
- host_rvalid  out  1  one-cycle pulse, host_rdata valid (reads only, coincides with host_done)
- host_rdata  out  DW  read data, held until next read completes
- host_err  out  1  one-cycle pulse with host_done on timeout abort
- cbus_req  out  1  request to arbiter
- cbus_cmd  out  1  1 = read, 0 = write
- cbus_addr  out  AW  request address
- cbus_wrdata  out  DW  request write data
- cbus_waccept  in  1  write granted this cycle (combinational from arbiter)
- cbus_rresp  in  1  read granted this cycle (combinational from arbiter)
- mem_rd_data  in  DW  memory read port data, valid one cycle after grant

## Operation
- FSM states: IDLE, REQ, RDATA.
- IDLE: host_ready=1. On host_req, latch cmd/addr/wdata into request registers, clear timeout counter, go to REQ.
- REQ: cbus_req=1; cbus_cmd/addr/wrdata driven from the latched registers and held stable every REQ cycle.
  - write & cbus_waccept: go to IDLE, host_done=1 next cycle.
  - read & cbus_rresp: go to RDATA.
  - A grant of the wrong type (waccept during a read, rresp during a write) is ignored.
  - No grant: increment timeout counter (saturating).
- RDATA: cbus_req=0. Register mem_rd_data into host_rdata. Go to IDLE with host_done=host_rvalid=1 next cycle.
- All host_* and cbus_* outputs are registered.
- Reset values: host_ready=1, all other outputs 0, host_rdata=0, state IDLE, counter 0.
- Reset asserted mid-transaction: the request is dropped immediately (cbus_req=0 asynchronously). No done pulse is issued.
- A host_req arriving while host_ready=0 is ignored. The host must hold it until ready.

## Timing
- Cycle 0: host_req & host_ready sampled.
- Cycle 1: cbus_req high.
- Write, granted in cycle N≥1: host_done and host_ready in cycle N+1.
- Read, granted in cycle N: RDATA in N+1, mem_rd_data sampled at end of N+1, host_rvalid/host_done/host_ready in N+2.
- Minimum latency: write 2 cycles, read 3 cycles, request to done.
- Back-to-back: a new command is accepted in the same cycle host_done pulses, and cbus_req reasserts the following cycle. Throughput is one write per 2 cycles and one read per 3 cycles.
- cbus_req never drops while in REQ except on grant or timeout.

## Configuration
- TP_CBUS_INIT_TIMEOUT_EN defined: the timeout counter is present.
  - The counter reaches TO_MAX in REQ without a matching grant, then cbus_req drops the next cycle.
  - host_done and host_err pulse, and the FSM returns to IDLE. host_rdata is unchanged.
  - A grant arriving in the same cycle the counter reaches TO_MAX wins; no error is raised.
- Undefined: the counter is removed, REQ waits indefinitely, host_err is tied 0, and TO_W/TO_MAX are unused.

## Structure
- Shared package tp_cbus_pkg:
  - state encoding localparams (IDLE=2'd0, REQ=2'd1, RDATA=2'd2)
  - cbus command constants CBUS_CMD_WR=1'b0, CBUS_CMD_RD=1'b1
- Single module, no sub-module. The timeout counter is inline under the macro.

## Test plan
- Write, no PHY traffic: host write addr 0x10 data 0xDEADBEEF, arbiter grants on first REQ cycle -> cbus_req high for 1 cycle with addr 0x10/data 0xDEADBEEF, host_done in cycle 2, host_err=0.
- Read with contention: read addr 0x20, rresp withheld 5 cycles, mem_rd_data=0x12345678 the cycle after grant -> cbus_req held 6 cycles with stable addr, host_rvalid with host_rdata=0x12345678 at cycle 8.
- Back-to-back: write then read issued on the host_done cycle -> second cbus_req rises one cycle after the first done, no idle gap beyond one cycle.
- Timeout (macro on, TO_MAX=4): write never granted -> cbus_req high exactly 5 cycles, then host_done+host_err pulse. Grant at count 4 -> done, host_err=0.
- Macro off: write ungranted 300 cycles -> cbus_req stays high, no done. Grant -> normal completion.
- Reset mid-REQ: rst_n low during read REQ -> cbus_req=0 immediately, host_ready=1 after release, no rvalid/done pulse.
